aes_frame_loader: RTL and testbench

//  Sits directly downstream of the I2C slave receiver. Captures its 264-bit (33-byte) frame

---
 rtl/aes_frame_loader.sv | 168 ++++++++++++++++
 tb/tb_aes_frame_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_frame_loader.sv
// Latches a 33-byte I2C frame on a frame_done rise, validates it, hands key/block to the AES core, holds the result.
// Optional KEY_REUSE_EN macro: command[1] selects the last accepted key instead of the frame key field.
module aes_frame_loader #(
    parameter int EXP_BYTES   = 33,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [263:0] frame_in,
    input  logic         frame_done,
    input  logic [9:0]   frame_bytes,
    output logic [127:0] aes_key,
    output logic [127:0] aes_block,
    output logic         aes_decrypt,
    output logic         aes_valid,
    input  logic         aes_ready,
    input  logic [127:0] aes_result,
    input  logic         aes_result_valid,
    output logic [127:0] result,
    output logic         result_valid,
    output logic         busy,
    output logic         err_format,
    output logic         err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_LOAD  = 3'd2,
        S_BUSY  = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic           frame_done_q;
    logic [263:0]   frame_q;
    logic [9:0]     bytes_q;
    logic [9:0]     cnt_q;
    logic [9:0]     cnt_inc;
    logic [127:0]   aes_key_q;
    logic [127:0]   aes_block_q;
    logic           aes_decrypt_q;
    logic           aes_valid_q;
    logic [127:0]   result_q;
    logic           result_valid_q;
    logic           err_format_q;
    logic           err_timeout_q;

    logic           rise;
    logic           trig;
    logic           fmt_ok;
    logic           accept;
    logic           timeout;
    logic [7:0]     cmd;
    logic [127:0]   key_sel;

    assign cmd     = frame_q[263:256];
    assign rise    = frame_done & ~frame_done_q;
    assign trig    = rise & ((state_q == S_IDLE) | (state_q == S_HOLD));
    assign accept  = (state_q == S_LOAD) & aes_ready;
    assign cnt_inc = (cnt_q == 10'h3FF) ? cnt_q : cnt_q + 10'd1;
    assign timeout = (state_q == S_BUSY) & ~aes_result_valid & (cnt_inc == 10'(TIMEOUT_CYC));

`ifdef KEY_REUSE_EN
    logic [127:0] stored_key_q;
    logic         key_valid_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stored_key_q <= '0;
            key_valid_q  <= 1'b0;
        end else if (accept) begin
            stored_key_q <= aes_key_q;
            key_valid_q  <= 1'b1;
        end
    end

    // command[1] requests the stored key; only legal once a key has been accepted
    assign fmt_ok  = (bytes_q == 10'(EXP_BYTES)) && (cmd[7:2] == 6'd0) && (!cmd[1] || key_valid_q);
    assign key_sel = cmd[1] ? stored_key_q : frame_q[255:128];
`else
    assign fmt_ok  = (bytes_q == 10'(EXP_BYTES)) && (cmd[7:1] == 7'd0);
    assign key_sel = frame_q[255:128];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_HOLD: if (trig) state_d = S_CHECK;
            S_CHECK:        state_d = fmt_ok ? S_LOAD : S_IDLE;
            S_LOAD:         if (aes_ready) state_d = S_BUSY;
            S_BUSY: begin
                if (aes_result_valid) state_d = S_HOLD;
                else if (timeout)     state_d = S_IDLE;
            end
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE) && (state_q != S_HOLD);
    end

    // frame_done_q resets high so a level already present at release is not an edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_done_q   <= 1'b1;
            frame_q        <= '0;
            bytes_q        <= '0;
            cnt_q          <= '0;
            aes_key_q      <= '0;
            aes_block_q    <= '0;
            aes_decrypt_q  <= 1'b0;
            aes_valid_q    <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            err_format_q   <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            frame_done_q <= frame_done;
            if (trig) begin
                frame_q        <= frame_in;
                bytes_q        <= frame_bytes;
                result_valid_q <= 1'b0;
                err_format_q   <= 1'b0;
                err_timeout_q  <= 1'b0;
            end
            if (state_q == S_CHECK) begin
                if (fmt_ok) begin
                    aes_key_q     <= key_sel;
                    aes_block_q   <= frame_q[127:0];
                    aes_decrypt_q <= cmd[0];
                    aes_valid_q   <= 1'b1;
                end else begin
                    err_format_q  <= 1'b1;
                end
            end
            if (accept) begin
                aes_valid_q <= 1'b0;
                cnt_q       <= '0;
            end
            if (state_q == S_BUSY) begin
                if (aes_result_valid) begin
                    result_q       <= aes_result;
                    result_valid_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_inc;
                    if (timeout) err_timeout_q <= 1'b1;
                end
            end
        end
    end

    assign aes_key      = aes_key_q;
    assign aes_block    = aes_block_q;
    assign aes_decrypt  = aes_decrypt_q;
    assign aes_valid    = aes_valid_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign err_format   = err_format_q;
    assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_aes_frame_loader.sv
// Directed bench for aes_frame_loader; expectations follow KEY_REUSE_EN when defined.
module tb_aes_frame_loader;

    logic         clk = 1'b0;
    logic         reset;
    logic [263:0] frame_in;
    logic         frame_done;
    logic [9:0]   frame_bytes;
    logic [127:0] aes_key;
    logic [127:0] aes_block;
    logic         aes_decrypt;
    logic         aes_valid;
    logic         aes_ready;
    logic [127:0] aes_result;
    logic         aes_result_valid;
    logic [127:0] result;
    logic         result_valid;
    logic         busy;
    logic         err_format;
    logic         err_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [127:0] K  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] B  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] R  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K3 = 128'hdeadbeef0123456789abcdeffedcba98;
    localparam logic [127:0] R2 = 128'h3925841d02dc09fbdc118597196a0b32;

    aes_frame_loader dut (
        .clk              (clk),
        .reset            (reset),
        .frame_in         (frame_in),
        .frame_done       (frame_done),
        .frame_bytes      (frame_bytes),
        .aes_key          (aes_key),
        .aes_block        (aes_block),
        .aes_decrypt      (aes_decrypt),
        .aes_valid        (aes_valid),
        .aes_ready        (aes_ready),
        .aes_result       (aes_result),
        .aes_result_valid (aes_result_valid),
        .result           (result),
        .result_valid     (result_valid),
        .busy             (busy),
        .err_format       (err_format),
        .err_timeout      (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset            = 1'b0;
        frame_in         = '0;
        frame_done       = 1'b1;
        frame_bytes      = 10'd0;
        aes_ready        = 1'b0;
        aes_result       = '0;
        aes_result_valid = 1'b0;

        // reset state
        #12;
        chk("rst_aes_valid", aes_valid, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_format", err_format, 0);
        chk("rst_err_timeout", err_timeout, 0);
        chk("rst_result", result, 0);
        chk("rst_aes_key", aes_key, 0);

        // frame_done already high at release: no trigger
        @(posedge clk); #1;
        reset = 1'b1;
        step(); step(); step();
        chk("no_trig_busy", busy, 0);
        chk("no_trig_valid", aes_valid, 0);
        frame_done = 1'b0;
        step();

        // nominal encrypt, AES answers 20 cycles after acceptance
        frame_in    = {8'h00, K, B};
        frame_bytes = 10'd33;
        aes_ready   = 1'b1;
        frame_done  = 1'b1;
        step();
        chk("t1_check_busy", busy, 1);
        chk("t1_check_valid", aes_valid, 0);
        step();
        chk("t1_valid", aes_valid, 1);
        chk("t1_key", aes_key, K);
        chk("t1_block", aes_block, B);
        chk("t1_decrypt", aes_decrypt, 0);
        step();
        chk("t1_accept_valid", aes_valid, 0);
        chk("t1_accept_busy", busy, 1);
        aes_ready = 1'b0;
        repeat (19) step();
        aes_result       = R;
        aes_result_valid = 1'b1;
        step();
        aes_result_valid = 1'b0;
        chk("t1_result_valid", result_valid, 1);
        chk("t1_result", result, R);
        chk("t1_hold_busy", busy, 0);
        frame_done = 1'b0;
        step();

        // wrong byte count
        frame_in    = {8'h00, K, B};
        frame_bytes = 10'd32;
        frame_done  = 1'b1;
        step(); step();
        chk("bytes32_err", err_format, 1);
        chk("bytes32_valid", aes_valid, 0);
        chk("bytes32_busy", busy, 0);
        chk("bytes32_rv_clr", result_valid, 0);
        frame_done = 1'b0;
        step();

        // reserved command bits
        frame_in    = {8'h80, K, B};
        frame_bytes = 10'd33;
        frame_done  = 1'b1;
        step(); step();
        chk("cmd80_err", err_format, 1);
        chk("cmd80_busy", busy, 0);
        step();
        chk("cmd80_valid", aes_valid, 0);
        frame_done = 1'b0;
        step();

        // decrypt with aes_ready stalled 5 cycles
        frame_in    = {8'h01, K2, B2};
        frame_done  = 1'b1;
        step();
        chk("stall_err_clr", err_format, 0);
        step();
        chk("stall_valid0", aes_valid, 1);
        chk("stall_decrypt", aes_decrypt, 1);
        chk("stall_key0", aes_key, K2);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", aes_valid, 1);
            chk("stall_key", aes_key, K2);
            chk("stall_block", aes_block, B2);
        end
        aes_ready = 1'b1;
        step();
        aes_ready = 1'b0;
        chk("stall_xfer_valid", aes_valid, 0);
        chk("stall_xfer_busy", busy, 1);

        // result withheld: timeout; a new rise during BUSY is ignored
        for (int i = 1; i <= 1022; i++) begin
            step();
            if (i == 5) frame_done = 1'b0;
            if (i == 10) begin
                frame_in    = {8'h00, K, B};
                frame_bytes = 10'd32;
                frame_done  = 1'b1;
            end
            if (i == 12) begin
                chk("busy_rise_busy", busy, 1);
                chk("busy_rise_valid", aes_valid, 0);
            end
        end
        chk("to_before", err_timeout, 0);
        chk("to_before_busy", busy, 1);
        step();
        chk("to_flag", err_timeout, 1);
        chk("to_idle", busy, 0);
        chk("to_no_fmt", err_format, 0);
        chk("to_rv", result_valid, 0);

        // stray result pulse in IDLE
        aes_result       = B;
        aes_result_valid = 1'b1;
        step();
        aes_result_valid = 1'b0;
        chk("stray_rv", result_valid, 0);
        chk("stray_busy", busy, 0);
        frame_done = 1'b0;
        step();

        // key reuse: frame1 loads K3, frame2 (from HOLD) asks for reuse
        frame_in    = {8'h00, K3, B};
        frame_bytes = 10'd33;
        aes_ready   = 1'b1;
        frame_done  = 1'b1;
        step(); step();
        chk("kr1_key", aes_key, K3);
        step();
        aes_ready        = 1'b0;
        aes_result       = R2;
        aes_result_valid = 1'b1;
        step();
        aes_result_valid = 1'b0;
        chk("kr1_rv", result_valid, 1);
        frame_done = 1'b0;
        step();
        frame_in   = {8'h02, 128'h0, B2};
        frame_done = 1'b1;
        step();
        chk("kr2_rv_clr", result_valid, 0);
        chk("kr2_busy", busy, 1);
        step();
`ifdef KEY_REUSE_EN
        chk("kr2_valid", aes_valid, 1);
        chk("kr2_key", aes_key, K3);
        chk("kr2_block", aes_block, B2);
        chk("kr2_err", err_format, 0);
`else
        chk("kr2_err", err_format, 1);
        chk("kr2_valid", aes_valid, 0);
`endif
        reset = 1'b0;
        step();
        reset = 1'b1;
        step(); step();
        chk("rel_high_busy", busy, 0);
        frame_done = 1'b0;
        step();

        // reset asserted in LOAD
        frame_in    = {8'h00, K, B};
        frame_bytes = 10'd33;
        frame_done  = 1'b1;
        step(); step();
        chk("rl_valid_pre", aes_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("rl_valid_async", aes_valid, 0);
        chk("rl_busy", busy, 0);
        chk("rl_result_lost", result, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        step(); step();
        chk("rl_after_busy", busy, 0);
        chk("rl_after_valid", aes_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
